// File: rtl/conv3x3_relu_stage.sv
// Streaming 3x3 valid-mode convolution with bias and ReLU over NUM_FILTERS kernels.
// Latency: accept of a window's bottom-right pixel + 1 edge; no backpressure, enable=0 freezes state.
// Optional RELU_SAT_EN: clamp relu_out to [0, 2^DATA_WIDTH-1] instead of plain ReLU.
module conv3x3_relu_stage #(
  parameter int IMG_WIDTH    = 28,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 20,
  parameter int NUM_FILTERS  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enable,
  input  logic [DATA_WIDTH-1:0]                  pixel_in,
  input  logic                                   pixel_valid,
  input  logic [NUM_FILTERS*9*WEIGHT_WIDTH-1:0]  weights,
  input  logic [NUM_FILTERS*WEIGHT_WIDTH-1:0]    bias,
  output logic [NUM_FILTERS*ACC_WIDTH-1:0]       conv_out,
  output logic [NUM_FILTERS*ACC_WIDTH-1:0]       relu_out,
  output logic                                   out_valid
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] TWO  = CW'(2);

  logic [CW-1:0]         row;
  logic [CW-1:0]         col;
  logic [DATA_WIDTH-1:0] lb_top [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb_mid [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] win [9];
  logic                  window_valid;
  logic                  accept;
  logic [DATA_WIDTH-1:0] top_pix;
  logic [DATA_WIDTH-1:0] mid_pix;

  assign accept  = enable && pixel_valid;
  assign top_pix = lb_top[col];
  assign mid_pix = lb_mid[col];

  // Line buffers: lb_mid holds the previous row, lb_top the row before it.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      lb_top[col] <= mid_pix;
      lb_mid[col] <= pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row          <= '0;
      col          <= '0;
      window_valid <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        win[k] <= '0;
      end
    end else if (enable) begin
      window_valid <= pixel_valid && (row >= TWO) && (col >= TWO);
      if (pixel_valid) begin
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= top_pix;
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= mid_pix;
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= pixel_in;
        if (col == LAST) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  function automatic logic signed [ACC_WIDTH-1:0] sext_w(input logic [WEIGHT_WIDTH-1:0] w);
    return {{(ACC_WIDTH-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w};
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] zext_p(input logic [DATA_WIDTH-1:0] p);
    return {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, p};
  endfunction

  // Operands are widened to ACC_WIDTH first so every product and partial sum is exact.
  logic signed [ACC_WIDTH-1:0] acc [NUM_FILTERS];

  always_comb begin
    for (int f = 0; f < NUM_FILTERS; f++) begin
      acc[f] = sext_w(bias[f*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      for (int k = 0; k < 9; k++) begin
        acc[f] = acc[f] + zext_p(win[k]) *
                 sext_w(weights[(f*9+k)*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= enable && window_valid;
      if (enable && window_valid) begin
        for (int f = 0; f < NUM_FILTERS; f++) begin
          conv_out[f*ACC_WIDTH +: ACC_WIDTH] <= acc[f];
        end
      end
    end
  end

`ifdef RELU_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << DATA_WIDTH) - 1);
`endif

  for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_relu
    logic signed [ACC_WIDTH-1:0] c;
    assign c = conv_out[f*ACC_WIDTH +: ACC_WIDTH];
`ifdef RELU_SAT_EN
    assign relu_out[f*ACC_WIDTH +: ACC_WIDTH] = c[ACC_WIDTH-1] ? '0 :
                                                (c > SAT_MAX) ? SAT_MAX : c;
`else
    assign relu_out[f*ACC_WIDTH +: ACC_WIDTH] = c[ACC_WIDTH-1] ? '0 : c;
`endif
  end

endmodule

// File: tb/tb_conv3x3_relu_stage.sv
// Scoreboard bench for conv3x3_relu_stage: reference image model, windows pushed on accept, popped on out_valid.
module tb_conv3x3_relu_stage;
  localparam int IW = 28;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int AW = 20;
  localparam int NF = 4;
  localparam int NPIX = IW * IW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               enable;
  logic [DW-1:0]      pixel_in;
  logic               pixel_valid;
  logic [NF*9*WW-1:0] weights;
  logic [NF*WW-1:0]   bias;
  logic [NF*AW-1:0]   conv_out;
  logic [NF*AW-1:0]   relu_out;
  logic               out_valid;

  conv3x3_relu_stage #(
    .IMG_WIDTH(IW), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .NUM_FILTERS(NF)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .weights(weights), .bias(bias), .conv_out(conv_out), .relu_out(relu_out), .out_valid(out_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  int kw [NF][9] = '{'{9, 11, -2, 1, -2, -11, -17, -9, -8},
                     '{-10, 7, 10, 0, 10, -1, 6, 4, -9},
                     '{-9, -14, 6, -3, -1, 4, 13, 7, -2},
                     '{3, 10, 9, -7, 6, 11, -16, -19, -16}};
  int kb [NF] = '{-10, -4, -15, 2};
  int ones_conv [NF] = '{-38, 13, -14, -17};
  int ones_relu [NF] = '{0, 13, 0, 0};

  typedef struct {
    int cyc;
    int v [NF];
  } exp_t;

  exp_t q [$];
  int   img [IW][IW];
  int   mr = 0;
  int   mc = 0;
  bit   pend = 1'b0;
  int   pend_val [NF];
  int   cyc = 0;
  int   last_k = 0;
  int   pulses = 0;
  int   first_cyc = -1;
  int   const_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint relu_m(input longint v);
    if (v < 0) return 0;
`ifdef RELU_SAT_EN
    if (v > 255) return 255;
`endif
    return v;
  endfunction

  function automatic int pix(input int mode, input int i);
    case (mode)
      1:       return 1;
      2:       return 255;
      3:       return (i * 91 + 17) & 255;
      default: return ((i * 37 + (i / IW) * 11) ^ (i >> 3)) & 255;
    endcase
  endfunction

  // One clock edge of stimulus; the model mirrors accept, window and output timing.
  task automatic step(input bit r_, input bit en, input bit v, input int p);
    rst = r_; enable = en; pixel_valid = v; pixel_in = p[DW-1:0];
    @(posedge clk);
    last_k = cyc;
    if (r_) begin
      pend = 1'b0; mr = 0; mc = 0;
    end else if (en) begin
      if (pend) begin
        exp_t e;
        e.cyc = cyc + 1;
        e.v   = pend_val;
        q.push_back(e);
      end
      pend = 1'b0;
      if (v) begin
        img[mr][mc] = p;
        if (mr >= 2 && mc >= 2) begin
          pend = 1'b1;
          for (int f = 0; f < NF; f++) begin
            pend_val[f] = kb[f];
            for (int k = 0; k < 9; k++)
              pend_val[f] += img[mr-2+k/3][mc-2+k%3] * kw[f][k];
          end
        end
        if (mc == IW - 1) begin
          mc = 0;
          mr = (mr == IW - 1) ? 0 : mr + 1;
        end else begin
          mc = mc + 1;
        end
      end
    end
    #1;
  endtask

  task automatic flush();
    repeat (4) step(1'b0, 1'b1, 1'b0, 0);
  endtask

  int acc58 = 0;

  task automatic frame(input int mode, input bit gaps, input int stall_at, input int stop_at);
    for (int i = 0; i < NPIX; i++) begin
      if (i == stop_at) return;
      step(1'b0, 1'b1, 1'b1, pix(mode, i));
      if (i == 58) acc58 = last_k;
      if (i == stall_at) repeat (5) step(1'b0, 1'b0, 1'b1, pix(mode, i + 1));
      if (gaps) step(1'b0, 1'b1, 1'b0, 0);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (pulses == 0) first_cyc = cyc;
      pulses++;
      if (q.size() == 0) begin
        check("spurious_pulse", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency", cyc, e.cyc);
        for (int f = 0; f < NF; f++) begin
          check($sformatf("conv%0d", f), $signed(conv_out[f*AW +: AW]), e.v[f]);
          check($sformatf("relu%0d", f), relu_out[f*AW +: AW], relu_m(e.v[f]));
          if (const_mode == 1) begin
            check($sformatf("ones_conv%0d", f), $signed(conv_out[f*AW +: AW]), ones_conv[f]);
            check($sformatf("ones_relu%0d", f), relu_out[f*AW +: AW], ones_relu[f]);
          end
        end
        if (const_mode == 2) begin
          check("w255_conv0", $signed(conv_out[0 +: AW]), -7150);
          check("w255_relu0", relu_out[0 +: AW], 0);
          check("w255_conv1", $signed(conv_out[AW +: AW]), 4331);
`ifdef RELU_SAT_EN
          check("w255_relu1", relu_out[AW +: AW], 255);
`else
          check("w255_relu1", relu_out[AW +: AW], 4331);
`endif
        end
      end
    end
  end

  initial begin
    for (int f = 0; f < NF; f++) begin
      bias[f*WW +: WW] = kb[f][WW-1:0];
      for (int k = 0; k < 9; k++) weights[(f*9+k)*WW +: WW] = kw[f][k][WW-1:0];
    end
    rst = 1'b1; enable = 1'b0; pixel_valid = 1'b0; pixel_in = '0;

    repeat (3) step(1'b1, 1'b0, 1'b0, 0);
    repeat (5) begin
      step(1'b0, 1'b1, 1'b0, 0);
      check("idle_out_valid", out_valid, 0);
      for (int f = 0; f < NF; f++) begin
        check("idle_conv", $signed(conv_out[f*AW +: AW]), 0);
        check("idle_relu", relu_out[f*AW +: AW], 0);
      end
    end

    pulses = 0; first_cyc = -1;
    frame(0, 1'b0, -1, -1);
    flush();
    check("count_frame", pulses, 676);
    check("first_pulse_cyc", first_cyc, acc58 + 2);

    const_mode = 1; pulses = 0;
    frame(1, 1'b0, -1, -1);
    flush();
    check("count_ones", pulses, 676);

    const_mode = 2; pulses = 0;
    frame(2, 1'b0, -1, -1);
    flush();
    check("count_255", pulses, 676);
    const_mode = 0;

    pulses = 0;
    frame(0, 1'b1, 400, -1);
    flush();
    check("count_stall", pulses, 676);

    pulses = 0;
    frame(0, 1'b0, -1, -1);
    frame(3, 1'b0, -1, -1);
    flush();
    check("count_two_frames", pulses, 1352);

    frame(3, 1'b0, -1, 300);
    step(1'b1, 1'b1, 1'b1, 99);
    pulses = 0;
    frame(0, 1'b0, -1, -1);
    flush();
    check("count_after_reset", pulses, 676);

    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
